// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with SRAM-like request/response channel
// Tracks one outstanding fetch, buffers redirects and drops stale responses.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  input  logic        fs_flush_pipe,
  input  logic [31:0] ex_entry,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  typedef enum logic [1:0] {EMPTY, WAIT, HOLD} fs_state_t;

  fs_state_t   fs_state;
  logic [31:0] pf_pc;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        redir_v;
  logic [31:0] redir_pc;
  logic        discard;

  logic        br_taken;
  logic [31:0] br_target;
  logic        redir;
  logic [31:0] redir_target;
  logic        req_accept;

  assign br_taken     = br_bus[32];
  assign br_target    = br_bus[31:0];
  assign redir        = fs_flush_pipe | br_taken;
  assign redir_target = fs_flush_pipe ? ex_entry : br_target;

  assign inst_sram_req   = (fs_state == EMPTY) & ~discard & ~reset;
  assign inst_sram_addr  = pf_pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'd0;
  assign req_accept      = inst_sram_req & inst_sram_addr_ok;

  // Zero-cycle path: data_ok in WAIT is offered to ID in the same cycle.
  assign fs_to_ds_valid = (((fs_state == WAIT) & inst_sram_data_ok) | (fs_state == HOLD))
                          & ~redir & ~reset;
  assign fs_to_ds_bus   = {((fs_state == HOLD) ? fs_inst : inst_sram_rdata), fs_pc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_state <= EMPTY;
      pf_pc    <= RESET_PC;
      fs_pc    <= 32'd0;
      fs_inst  <= 32'd0;
      redir_v  <= 1'b0;
      redir_pc <= 32'd0;
      discard  <= 1'b0;
    end else begin
      case (fs_state)
        EMPTY: begin
          if (req_accept) begin
            if (redir || redir_v) begin
              // The accepted address is stale; its response must be dropped.
              discard <= 1'b1;
              redir_v <= 1'b0;
              pf_pc   <= redir ? redir_target : redir_pc;
            end else begin
              fs_pc    <= pf_pc;
              pf_pc    <= pf_pc + 32'd4;
              fs_state <= WAIT;
            end
          end else if (inst_sram_req && redir) begin
            redir_v  <= 1'b1;
            redir_pc <= redir_target;
          end else if (redir) begin
            pf_pc <= redir_target;
          end
          if (discard && inst_sram_data_ok) begin
            discard <= 1'b0;
          end
        end
        WAIT: begin
          if (redir) begin
            pf_pc    <= redir_target;
            fs_state <= EMPTY;
            discard  <= ~inst_sram_data_ok;
          end else if (inst_sram_data_ok) begin
            if (ds_allowin) begin
              fs_state <= EMPTY;
            end else begin
              fs_inst  <= inst_sram_rdata;
              fs_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redir) begin
            pf_pc    <= redir_target;
            fs_state <= EMPTY;
          end else if (ds_allowin) begin
            fs_state <= EMPTY;
          end
        end
        default: fs_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
// Directed vector table, hand sequences for reset corners, then random traffic vs a PC-stream model.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h1C000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ds_allowin = 1'b0;
  logic [32:0] br_bus = 33'd0;
  logic        fs_flush_pipe = 1'b0;
  logic [31:0] ex_entry = 32'd0;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = 32'd0;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .reset            (reset),
    .ds_allowin       (ds_allowin),
    .br_bus           (br_bus),
    .fs_flush_pipe    (fs_flush_pipe),
    .ex_entry         (ex_entry),
    .fs_to_ds_valid   (fs_to_ds_valid),
    .fs_to_ds_bus     (fs_to_ds_bus),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_wr     (inst_sram_wr),
    .inst_sram_size   (inst_sram_size),
    .inst_sram_wstrb  (inst_sram_wstrb),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_wdata  (inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata  (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        aok, dok, alw, br, fl;
    logic [31:0] tgt, ex;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A3C3C;
  endfunction

  function automatic vec_t mk(input logic aok, dok, alw, br, fl, input logic [31:0] tgt, ex,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic evalid, input logic [31:0] epc);
    vec_t v;
    v.aok = aok; v.dok = dok; v.alw = alw; v.br = br; v.fl = fl;
    v.tgt = tgt; v.ex = ex; v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; ds_allowin = 1'b0;
    br_bus = 33'd0; fs_flush_pipe = 1'b0; ex_entry = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, inst_sram_req}, 32'd0);
    chk("rst_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    chk("rst_fs_pc", fs_to_ds_bus[31:0], 32'd0);
    chk("rst_addr", inst_sram_addr, RESET_PC);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("first_req", {31'd0, inst_sram_req}, 32'd1);
    chk("first_addr", inst_sram_addr, RESET_PC);
  endtask

  logic [31:0] last_acc;
  logic        outstanding, dok, r, prev_req_pend, hold_pend;
  logic [31:0] out_addr, exp_pc, t, prev_addr, tgt, ex;
  logic [63:0] prev_bus;
  logic [13:0] rnd;
  int          out_cnt, handoffs;

  initial begin
    // Directed table: in-order fetch, HOLD, buffered redirect, WAIT redirect,
    // flush-over-branch in HOLD, redirect coinciding with data_ok.
    tbl.push_back(mk(1,0,1,0,0, 0,0, 1,32'h1C000000, 0,0));
    tbl.push_back(mk(1,1,1,0,0, 0,0, 0,0, 1,32'h1C000000));
    tbl.push_back(mk(1,0,1,0,0, 0,0, 1,32'h1C000004, 0,0));
    tbl.push_back(mk(1,1,1,0,0, 0,0, 0,0, 1,32'h1C000004));
    tbl.push_back(mk(1,0,1,0,0, 0,0, 1,32'h1C000008, 0,0));
    tbl.push_back(mk(1,1,1,0,0, 0,0, 0,0, 1,32'h1C000008));
    tbl.push_back(mk(1,0,1,0,0, 0,0, 1,32'h1C00000C, 0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0, 0,0, 1,32'h1C00000C));
    tbl.push_back(mk(0,0,0,0,0, 0,0, 0,0, 1,32'h1C00000C));
    tbl.push_back(mk(0,0,0,0,0, 0,0, 0,0, 1,32'h1C00000C));
    tbl.push_back(mk(0,0,1,0,0, 0,0, 0,0, 1,32'h1C00000C));
    tbl.push_back(mk(0,0,1,0,0, 0,0, 1,32'h1C000010, 0,0));
    tbl.push_back(mk(0,0,1,1,0, 32'h1C000100,0, 1,32'h1C000010, 0,0));
    tbl.push_back(mk(0,0,1,0,0, 0,0, 1,32'h1C000010, 0,0));
    tbl.push_back(mk(1,0,1,0,0, 0,0, 1,32'h1C000010, 0,0));
    tbl.push_back(mk(1,0,1,0,0, 0,0, 0,0, 0,0));
    tbl.push_back(mk(1,1,1,0,0, 0,0, 0,0, 0,0));
    tbl.push_back(mk(1,0,1,0,0, 0,0, 1,32'h1C000100, 0,0));
    tbl.push_back(mk(0,0,1,1,0, 32'h1C000100,0, 0,0, 0,0));
    tbl.push_back(mk(1,0,1,0,0, 0,0, 0,0, 0,0));
    tbl.push_back(mk(1,1,1,0,0, 0,0, 0,0, 0,0));
    tbl.push_back(mk(1,0,1,0,0, 0,0, 1,32'h1C000100, 0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0, 0,0, 1,32'h1C000100));
    tbl.push_back(mk(0,0,1,1,1, 32'h1C000100,32'h1C008000, 0,0, 0,0));
    tbl.push_back(mk(1,0,1,0,0, 0,0, 1,32'h1C008000, 0,0));
    tbl.push_back(mk(0,1,1,0,0, 0,0, 0,0, 1,32'h1C008000));
    tbl.push_back(mk(1,0,1,0,0, 0,0, 1,32'h1C008004, 0,0));
    tbl.push_back(mk(0,1,1,1,0, 32'h1C000040,0, 0,0, 0,0));
    tbl.push_back(mk(1,0,1,0,0, 0,0, 1,32'h1C000040, 0,0));
    tbl.push_back(mk(0,1,1,0,0, 0,0, 0,0, 1,32'h1C000040));

    do_reset();
    chk("tied_wr_size_wstrb", {25'd0, inst_sram_wr, inst_sram_size, inst_sram_wstrb}, {25'd0, 1'b0, 2'b10, 4'b0000});
    chk("tied_wdata", inst_sram_wdata, 32'd0);
    last_acc = 32'd0;
    foreach (tbl[i]) begin
      @(negedge clk);
      inst_sram_addr_ok = tbl[i].aok;
      inst_sram_data_ok = tbl[i].dok;
      inst_sram_rdata   = tbl[i].dok ? inst_of(last_acc) : $urandom;
      ds_allowin        = tbl[i].alw;
      br_bus            = {tbl[i].br, tbl[i].tgt};
      fs_flush_pipe     = tbl[i].fl;
      ex_entry          = tbl[i].ex;
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, inst_sram_req}, {31'd0, tbl[i].ereq});
      if (tbl[i].ereq) chk($sformatf("v%0d_addr", i), inst_sram_addr, tbl[i].eaddr);
      chk($sformatf("v%0d_valid", i), {31'd0, fs_to_ds_valid}, {31'd0, tbl[i].evalid});
      if (tbl[i].evalid) begin
        chk($sformatf("v%0d_pc", i), fs_to_ds_bus[31:0], tbl[i].epc);
        chk($sformatf("v%0d_inst", i), fs_to_ds_bus[63:32], inst_of(tbl[i].epc));
      end
      if (inst_sram_req && inst_sram_addr_ok) last_acc = inst_sram_addr;
    end

    // Asynchronous reset in the middle of a WAIT cycle with data being offered.
    do_reset();
    @(negedge clk);
    inst_sram_addr_ok = 1'b1; ds_allowin = 1'b0; br_bus = 33'd0; fs_flush_pipe = 1'b0;
    @(negedge clk);
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata = inst_of(RESET_PC);
    #1;
    chk("async_pre_valid", {31'd0, fs_to_ds_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_valid_drop", {31'd0, fs_to_ds_valid}, 32'd0);
    chk("async_req_drop", {31'd0, inst_sram_req}, 32'd0);
    inst_sram_data_ok = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async_after_req", {31'd0, inst_sram_req}, 32'd1);
    chk("async_after_addr", inst_sram_addr, RESET_PC);

    // Random traffic: handoffs must follow the sequential PC stream, re-seeded at every redirect.
    do_reset();
    outstanding = 1'b0; out_cnt = 0; out_addr = 32'd0;
    exp_pc = RESET_PC; hold_pend = 1'b0; prev_bus = 64'd0;
    prev_req_pend = 1'b1; prev_addr = RESET_PC; handoffs = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      dok = outstanding && (out_cnt == 0);
      inst_sram_addr_ok = ($urandom_range(0, 2) != 0);
      inst_sram_data_ok = dok;
      inst_sram_rdata   = dok ? inst_of(out_addr) : $urandom;
      ds_allowin        = ($urandom_range(0, 9) < 7);
      rnd = 14'($urandom);
      tgt = {16'h1C00, rnd, 2'b00};
      rnd = 14'($urandom);
      ex  = {16'h1C01, rnd, 2'b00};
      br_bus        = {($urandom_range(0, 99) < 8), tgt};
      fs_flush_pipe = ($urandom_range(0, 99) < 4);
      ex_entry      = ex;
      #1;
      r = br_bus[32] | fs_flush_pipe;
      t = fs_flush_pipe ? ex_entry : br_bus[31:0];
      if (prev_req_pend) begin
        chk("rnd_req_held", {31'd0, inst_sram_req}, 32'd1);
        chk("rnd_addr_stable", inst_sram_addr, prev_addr);
      end
      if (inst_sram_req) chk("rnd_one_outstanding", {31'd0, outstanding}, 32'd0);
      if (r) begin
        chk("rnd_valid_on_redirect", {31'd0, fs_to_ds_valid}, 32'd0);
        exp_pc = t;
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          chk("rnd_hold_valid", {31'd0, fs_to_ds_valid}, 32'd1);
          chk("rnd_hold_bus_inst", fs_to_ds_bus[63:32], prev_bus[63:32]);
          chk("rnd_hold_bus_pc", fs_to_ds_bus[31:0], prev_bus[31:0]);
        end
        if (fs_to_ds_valid) begin
          chk("rnd_pc", fs_to_ds_bus[31:0], exp_pc);
          chk("rnd_inst", fs_to_ds_bus[63:32], inst_of(exp_pc));
          if (ds_allowin) begin
            exp_pc = exp_pc + 32'd4;
            hold_pend = 1'b0;
            handoffs++;
          end else begin
            hold_pend = 1'b1;
            prev_bus = fs_to_ds_bus;
          end
        end
      end
      if (dok) outstanding = 1'b0;
      else if (outstanding) out_cnt--;
      if (inst_sram_req && inst_sram_addr_ok) begin
        outstanding = 1'b1;
        out_addr = inst_sram_addr;
        out_cnt = $urandom_range(0, 3);
      end
      prev_req_pend = inst_sram_req && !inst_sram_addr_ok;
      prev_addr = inst_sram_addr;
    end
    chk("rnd_handoffs_seen", {31'd0, (handoffs > 200)}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1C000000: address of the first fetch after reset.
REQ-002 SHALL have port clk  in  1: the single clock; all state on its rising edge.
REQ-003 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-004 SHALL have port ds_allowin  in  1: ID stage can accept an instruction this cycle.
REQ-005 SHALL have port br_bus  in  33: {br_taken[32], br_target[31:0]}; br_taken is already qualified by ID validity.
REQ-006 SHALL have port fs_flush_pipe  in  1: exception/ertn redirect pulse.
REQ-007 SHALL have port ex_entry  in  32: redirect target when fs_flush_pipe=1.
REQ-008 SHALL have port fs_to_ds_valid  out  1: instruction offered to ID.
REQ-009 SHALL have port fs_to_ds_bus  out  64: {inst[63:32], pc[31:0]}.
REQ-010 SHALL have ports inst_sram_req out 1, inst_sram_wr out 1, inst_sram_size out 2, inst_sram_wstrb out 4, inst_sram_addr out 32, inst_sram_wdata out 32: SRAM-like request channel.
REQ-011 SHALL have ports inst_sram_addr_ok in 1, inst_sram_data_ok in 1, inst_sram_rdata in 32: SRAM-like response channel.

Function
REQ-012 SHALL tie inst_sram_wr=0, inst_sram_size=2'b10, inst_sram_wstrb=0, inst_sram_wdata=0.
REQ-013 SHALL hold registers pf_pc, fs_pc, fs_inst, redir_v, redir_pc, discard, and state fs_state in {EMPTY, WAIT, HOLD}.
REQ-014 SHALL drive inst_sram_req = (fs_state==EMPTY) & !discard & !reset, and inst_sram_addr = pf_pc.
REQ-015 SHALL keep at most one request outstanding; once req=1, addr SHALL stay stable until addr_ok.
REQ-016 SHALL define redirect R = fs_flush_pipe | br_taken, with target T = fs_flush_pipe ? ex_entry : br_target. Flush SHALL win over branch.
REQ-017 SHALL, on req&addr_ok without R and with redir_v=0, set fs_pc<=pf_pc, pf_pc<=pf_pc+4 (mod 2^32), and fs_state<=WAIT.
REQ-018 SHALL, on req&addr_ok with R or redir_v, keep fs_state=EMPTY and set discard<=1, redir_v<=0, and pf_pc<=(R ? T : redir_pc).
REQ-019 SHALL, on R while req=1 and addr_ok=0, set redir_v<=1 and redir_pc<=T; a later R SHALL overwrite redir_pc.
REQ-020 SHALL, on R in EMPTY with discard=1, set pf_pc<=T directly.
REQ-021 SHALL, on R in WAIT, set pf_pc<=T and fs_state<=EMPTY; discard<=1 unless data_ok is high the same cycle, in which case that data is dropped and discard stays 0.
REQ-022 SHALL, on R in HOLD, set fs_state<=EMPTY and pf_pc<=T, dropping fs_inst.
REQ-023 SHALL, on data_ok with discard=1, drop rdata and clear discard.
REQ-024 SHALL, in WAIT on data_ok without R, go to EMPTY if ds_allowin=1; otherwise it SHALL set fs_inst<=rdata and go to HOLD.
REQ-025 SHALL, in HOLD on ds_allowin without R, go to EMPTY.
REQ-026 SHALL drive fs_to_ds_valid = ((WAIT & data_ok) | HOLD) & !R, giving a combinational 0-cycle data_ok-to-ID path.
REQ-027 SHALL drive fs_to_ds_bus = {(HOLD ? fs_inst : inst_sram_rdata), fs_pc}.
REQ-028 SHALL keep fs_to_ds_bus stable while in HOLD.

Reset
REQ-029 SHALL, while reset=1 (asynchronously), force fs_state=EMPTY, pf_pc=RESET_PC, discard=0, redir_v=0, fs_pc=0, fs_inst=0, inst_sram_req=0, and fs_to_ds_valid=0.
REQ-030 SHALL issue the first request with addr=RESET_PC in the first cycle after reset deasserts.
REQ-031 SHALL abandon any in-flight request on reset; the bench resets the SRAM model together with this block.

Verification
REQ-032 Reset release; addr_ok=1; data_ok one cycle after acceptance; ds_allowin=1 -> addrs 0x1C000000, 0x1C000004, 0x1C000008; each fs_to_ds_valid pulse carries the matching pc.
REQ-033 ds_allowin=0 at data_ok for 3 cycles -> HOLD; bus stable; req=0; ds_allowin=1 -> one handoff; next req with addr=pc+4 on the following cycle.
REQ-034 br_taken, br_target=0x1C000100, in WAIT -> returning data dropped; fs_to_ds_valid stays 0; next req addr=0x1C000100, issued only after discard clears.
REQ-035 br_taken (target 0x1C000100) while req=1 and addr_ok=0 for 2 cycles -> addr stays at the old value; on acceptance the data is discarded; next req addr=0x1C000100.
REQ-036 fs_flush_pipe with ex_entry=0x1C008000 and br_taken with target 0x1C000100 in the same cycle in HOLD -> instruction dropped; next req addr=0x1C008000.
REQ-037 Async reset asserted mid-WAIT -> req and fs_to_ds_valid fall to 0 without waiting for a clock edge; after release, first addr=0x1C000000.
